// File: rtl/map_fwd_sched.sv
// Forward-recursion step scheduler for the MAP decoder: walks trellis steps window by
// window, hands completed windows to the backward side, and throttles on alpha-buffer credits.
module map_fwd_sched #(
    parameter int WIN_LEN   = 4,
    parameter int NUM_WIN   = 3,
    parameter int MAX_AHEAD = 2,
    parameter int AW        = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          step_ready,
    input  logic          bck_win_ack,
    output logic          step_valid,
    output logic [3:0]    step_idx,
    output logic [3:0]    win_idx,
    output logic [AW-1:0] alpha_waddr,
    output logic          init_alpha,
    output logic          win_done,
    output logic [1:0]    ahead_cnt,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RUN, WAIT_BUF, DRAIN} state_t;

    localparam logic [3:0]    STEP_LAST = 4'(WIN_LEN - 1);
    localparam logic [3:0]    WIN_LAST  = 4'(NUM_WIN - 1);
    localparam logic [1:0]    AHEAD_MAX = 2'(MAX_AHEAD);
    localparam logic [AW-1:0] BASE_STEP = AW'(WIN_LEN);
    localparam logic [AW-1:0] BASE_LAST = AW'((MAX_AHEAD - 1) * WIN_LEN);

    state_t        state, state_nxt;
    logic [3:0]    step_nxt, win_nxt;
    logic [1:0]    ahead_nxt;
    logic [AW-1:0] base, base_nxt;
    logic          win_done_nxt, done_nxt;
    logic          accept, last_step, last_win, win_complete, ack_eff;

    assign accept       = (state == RUN) && step_ready;
    assign last_step    = (step_idx == STEP_LAST);
    assign last_win     = (win_idx == WIN_LAST);
    assign win_complete = accept && last_step;
    assign ack_eff      = bck_win_ack && (ahead_cnt != 2'd0);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            step_idx  <= '0;
            win_idx   <= '0;
            base      <= '0;
            ahead_cnt <= '0;
            win_done  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_idx  <= step_nxt;
            win_idx   <= win_nxt;
            base      <= base_nxt;
            ahead_cnt <= ahead_nxt;
            win_done  <= win_done_nxt;
            done      <= done_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt    = state;
        step_nxt     = step_idx;
        win_nxt      = win_idx;
        base_nxt     = base;
        win_done_nxt = 1'b0;
        done_nxt     = 1'b0;
        ahead_nxt    = ahead_cnt + {1'b0, win_complete} - {1'b0, ack_eff};

        if (abort) begin
            state_nxt = IDLE;
            step_nxt  = '0;
            win_nxt   = '0;
            base_nxt  = '0;
            ahead_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = RUN;
                        step_nxt  = '0;
                        win_nxt   = '0;
                        base_nxt  = '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_step) begin
                            step_nxt     = '0;
                            win_nxt      = win_idx + 4'd1;
                            // Slot base walks 0, WIN_LEN, ... and wraps after the last buffer slot.
                            base_nxt     = (base == BASE_LAST) ? '0 : base + BASE_STEP;
                            win_done_nxt = 1'b1;
                            if (last_win)
                                state_nxt = DRAIN;
                            else if (ahead_nxt >= AHEAD_MAX)
                                state_nxt = WAIT_BUF;
                        end else begin
                            step_nxt = step_idx + 4'd1;
                        end
                    end
                end
                WAIT_BUF: begin
                    if (ahead_nxt < AHEAD_MAX)
                        state_nxt = RUN;
                end
                DRAIN: begin
                    if (ahead_nxt == 2'd0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        win_nxt   = '0;
                        base_nxt  = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        step_valid  = (state == RUN);
        busy        = (state != IDLE);
        init_alpha  = step_valid && (step_idx == 4'd0) && (win_idx == 4'd0);
        alpha_waddr = base + AW'(step_idx);
    end

endmodule
